// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: load-use and mult/div stalls, taken-redirect flushes; HAZARD_STATS_EN adds a stall counter.
// All outputs are combinational (zero-cycle); a stall freezes PC and IF/ID and bubbles ID/EX, and a redirect overrides it.
module pipe_hazard_ctrl #(
  parameter int MD_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       id_md_start,
  input  logic       id_md_use,
  input  logic       ex_redirect,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       md_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] stall_count
`endif
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] md_cnt_q, md_cnt_d;
  logic       load_hz;
  logic       md_hz;
  logic       stall;

  assign load_hz = ex_mem_read && (ex_rt != 5'd0) &&
                   ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
  assign md_hz   = (state_q == MD_BUSY) && (id_md_start || id_md_use);
  assign stall   = (load_hz || md_hz) && !ex_redirect;
  assign md_busy = (state_q == MD_BUSY);

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // A redirect kills the issuing instruction, but never an op already in flight.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      RUN: begin
        if (id_md_start && !stall && !ex_redirect) begin
          state_d  = MD_BUSY;
          md_cnt_d = 6'(MD_CYCLES - 1);
        end
      end
      MD_BUSY: begin
        if (md_cnt_q == 6'd0) begin
          state_d = RUN;
        end else begin
          md_cnt_d = md_cnt_q - 6'd1;
        end
      end
      default: begin
        state_d  = RUN;
        md_cnt_d = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      md_cnt_q <= 6'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= 16'd0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MD_CYCLES=4; obs packs {pc_write, if_id_write, if_id_flush, id_ex_flush, md_busy}.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       ex_mem_read;
  logic [4:0] ex_rt;
  logic       id_md_start;
  logic       id_md_use;
  logic       ex_redirect;
  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       md_busy;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count;
`endif

  logic [4:0] obs;
  int checks;
  int errors;

  assign obs = {pc_write, if_id_write, if_id_flush, id_ex_flush, md_busy};

  pipe_hazard_ctrl #(.MD_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .id_md_start (id_md_start),
    .id_md_use   (id_md_use),
    .ex_redirect (ex_redirect),
    .pc_write    (pc_write),
    .if_id_write (if_id_write),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .md_busy     (md_busy)
`ifdef HAZARD_STATS_EN
    ,
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    id_rs       = 5'd0;
    id_rt       = 5'd0;
    id_uses_rs  = 1'b0;
    id_uses_rt  = 1'b0;
    ex_mem_read = 1'b0;
    ex_rt       = 5'd0;
    id_md_start = 1'b0;
    id_md_use   = 1'b0;
    ex_redirect = 1'b0;
  endtask

  // Advance to just after the next rising edge; inputs are then changed and checked before the following edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1'b1;
    ex_rt       = 5'd8;
    id_rs       = 5'd8;
    id_uses_rs  = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #1;
    checks++;
    if (obs !== 5'b11000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", obs, 5'b11000);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_load_use();
    set_load_use();
    #1;
    checks++;
    if (obs !== 5'b00010) begin
      errors++;
      $display("FAIL load_use_rs: got %b expected %b", obs, 5'b00010);
    end
    step();
    idle();
    #1;
    checks++;
    if (obs !== 5'b11000) begin
      errors++;
      $display("FAIL load_use_released: got %b expected %b", obs, 5'b11000);
    end
    step();
    ex_mem_read = 1'b1;
    ex_rt       = 5'd0;
    id_rs       = 5'd0;
    id_uses_rs  = 1'b1;
    #1;
    checks++;
    if (obs !== 5'b11000) begin
      errors++;
      $display("FAIL load_use_r0: got %b expected %b", obs, 5'b11000);
    end
    step();
    idle();
    ex_mem_read = 1'b1;
    ex_rt       = 5'd5;
    id_rt       = 5'd5;
    id_uses_rt  = 1'b1;
    #1;
    checks++;
    if (obs !== 5'b00010) begin
      errors++;
      $display("FAIL load_use_rt: got %b expected %b", obs, 5'b00010);
    end
    step();
    id_uses_rt = 1'b0;
    id_rs      = 5'd5;
    #1;
    checks++;
    if (obs !== 5'b11000) begin
      errors++;
      $display("FAIL load_use_unused_src: got %b expected %b", obs, 5'b11000);
    end
    step();
    idle();
  endtask

  task automatic test_redirect();
    set_load_use();
    ex_redirect = 1'b1;
    #1;
    checks++;
    if (obs !== 5'b11110) begin
      errors++;
      $display("FAIL redirect_over_stall: got %b expected %b", obs, 5'b11110);
    end
    step();
    idle();
    ex_redirect = 1'b1;
    #1;
    checks++;
    if (obs !== 5'b11110) begin
      errors++;
      $display("FAIL redirect_alone: got %b expected %b", obs, 5'b11110);
    end
    step();
    idle();
  endtask

  task automatic test_md_use();
    id_md_start = 1'b1;
    #1;
    checks++;
    if (obs !== 5'b11000) begin
      errors++;
      $display("FAIL md_issue: got %b expected %b", obs, 5'b11000);
    end
    step();
    idle();
    id_md_use = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (obs !== 5'b00011) begin
        errors++;
        $display("FAIL md_use_stall_%0d: got %b expected %b", i, obs, 5'b00011);
      end
      step();
    end
    #1;
    checks++;
    if (obs !== 5'b11000) begin
      errors++;
      $display("FAIL md_use_issue_cycle5: got %b expected %b", obs, 5'b11000);
    end
    step();
    idle();
  endtask

  task automatic test_md_start_with_load();
    set_load_use();
    id_md_start = 1'b1;
    #1;
    checks++;
    if (obs !== 5'b00010) begin
      errors++;
      $display("FAIL md_start_load_stall: got %b expected %b", obs, 5'b00010);
    end
    step();
    idle();
    id_md_start = 1'b1;
    #1;
    checks++;
    if (obs !== 5'b11000) begin
      errors++;
      $display("FAIL md_start_not_issued_early: got %b expected %b", obs, 5'b11000);
    end
    step();
    idle();
    #1;
    checks++;
    if (obs !== 5'b11001) begin
      errors++;
      $display("FAIL md_start_issued_late: got %b expected %b", obs, 5'b11001);
    end
    step();
    step();
    step();
    step();
    #1;
    checks++;
    if (md_busy !== 1'b0) begin
      errors++;
      $display("FAIL md_start_load_done: got %b expected %b", md_busy, 1'b0);
    end
  endtask

  task automatic test_redirect_in_md();
    id_md_start = 1'b1;
    step();
    idle();
    id_md_use   = 1'b1;
    ex_redirect = 1'b1;
    #1;
    checks++;
    if (obs !== 5'b11111) begin
      errors++;
      $display("FAIL redirect_in_md: got %b expected %b", obs, 5'b11111);
    end
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (md_busy !== 1'b1) begin
        errors++;
        $display("FAIL md_continues_%0d: got %b expected %b", i, md_busy, 1'b1);
      end
      step();
    end
    #1;
    checks++;
    if (md_busy !== 1'b0) begin
      errors++;
      $display("FAIL md_after_redirect_done: got %b expected %b", md_busy, 1'b0);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int busy_cycles;
    int stall_cycles;
    busy_cycles  = 0;
    stall_cycles = 0;
    idle();
    for (int c = 0; c < 10; c++) begin
      id_md_start = (c <= 5);
      #1;
      if (md_busy === 1'b1) busy_cycles++;
      if (pc_write === 1'b0) stall_cycles++;
      step();
    end
    idle();
    checks++;
    if (busy_cycles !== 8) begin
      errors++;
      $display("FAIL b2b_busy_cycles: got %0d expected %0d", busy_cycles, 8);
    end
    checks++;
    if (stall_cycles !== 4) begin
      errors++;
      $display("FAIL b2b_stall_cycles: got %0d expected %0d", stall_cycles, 4);
    end
    #1;
    checks++;
    if (md_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_after: got %b expected %b", md_busy, 1'b0);
    end
    step();
  endtask

  task automatic test_reset_mid_op();
    id_md_start = 1'b1;
    step();
    idle();
    step();
    id_md_use = 1'b1;
    #1;
    checks++;
    if (obs !== 5'b00011) begin
      errors++;
      $display("FAIL mid_op_busy_before_reset: got %b expected %b", obs, 5'b00011);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 5'b11000) begin
      errors++;
      $display("FAIL mid_op_async_reset: got %b expected %b", obs, 5'b11000);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (obs !== 5'b11000) begin
        errors++;
        $display("FAIL mid_op_no_residual_%0d: got %b expected %b", i, obs, 5'b11000);
      end
      step();
    end
    idle();
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    set_load_use();
    step();
    step();
    step();
    idle();
    #1;
    checks++;
    if (stall_count !== 16'd3) begin
      errors++;
      $display("FAIL stats_three: got %0d expected %0d", stall_count, 3);
    end
    force dut.stall_count_q = 16'hFFFF;
    #1;
    release dut.stall_count_q;
    set_load_use();
    step();
    idle();
    #1;
    checks++;
    if (stall_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL stats_saturate: got %h expected %h", stall_count, 16'hFFFF);
    end
    step();
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load_use();
    test_redirect();
    test_md_use();
    test_md_start_with_load();
    test_redirect_in_md();
    test_back_to_back();
    test_reset_mid_op();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: MD_CYCLES, default 32, mult/div unit occupancy in cycles (legal range 2..63).
REQ-002 clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 id_rs  input  5  rs field of the instruction in ID.
REQ-005 id_rt  input  5  rt field of the instruction in ID.
REQ-006 id_uses_rs / id_uses_rt  input  1 each  ID instruction reads rs / rt.
REQ-007 ex_mem_read  input  1  instruction in EX (the ID/EX register output) is a load.
REQ-008 ex_rt  input  5  destination register of the load in EX.
REQ-009 id_md_start  input  1  ID instruction is MULT/MULTU/DIV/DIVU.
REQ-010 id_md_use  input  1  ID instruction is MFHI/MFLO/MTHI/MTLO.
REQ-011 ex_redirect  input  1  taken branch or jump resolved in EX this cycle.
REQ-012 pc_write  output  1  PC may update.
REQ-013 if_id_write  output  1  IF/ID register may load.
REQ-014 if_id_flush  output  1  IF/ID loads a NOP.
REQ-015 id_ex_flush  output  1  ID/EX loads a bubble (all control bits zero).
REQ-016 md_busy  output  1  mult/div unit occupied.

Function
REQ-017 load_hz SHALL be ex_mem_read & (ex_rt != 0) & ((id_uses_rs & id_rs == ex_rt) | (id_uses_rt & id_rt == ex_rt)).
REQ-018 FSM SHALL have two states: RUN and MD_BUSY, plus a 6-bit down-counter md_cnt.
REQ-019 md_hz SHALL be (state == MD_BUSY) & (id_md_start | id_md_use); always 0 in RUN.
REQ-020 stall SHALL be (load_hz | md_hz) & ~ex_redirect; stall, flush and all outputs are combinational from current state and inputs (zero-cycle latency).
REQ-021 When stall=1: pc_write=0, if_id_write=0, id_ex_flush=1, if_id_flush=0.
REQ-022 When ex_redirect=1: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1; redirect overrides any stall in the same cycle.
REQ-023 Otherwise: pc_write=1, if_id_write=1, both flushes 0.
REQ-024 RUN -> MD_BUSY when id_md_start=1, stall=0 and ex_redirect=0; md_cnt loads MD_CYCLES-1.
REQ-025 In MD_BUSY md_cnt SHALL decrement by 1 each cycle; at md_cnt==0 state returns to RUN on that edge.
REQ-026 A new id_md_start while in MD_BUSY SHALL stall until RUN, then issue per REQ-024 (back-to-back ops never overlap).
REQ-027 ex_redirect in MD_BUSY SHALL NOT abort the in-flight mult/div; counting continues.
REQ-028 md_busy SHALL equal (state == MD_BUSY).
REQ-029 An id_md_start that coincides with load_hz SHALL NOT issue; it issues on the first unstalled cycle.

Reset
REQ-030 rst_n low SHALL immediately force state=RUN, md_cnt=0; outputs then follow REQ-023 (pc_write=1, if_id_write=1, flushes 0, md_busy=0).
REQ-031 Reset asserted during MD_BUSY SHALL abandon the operation with no residual stall after release.

Configuration
REQ-032 Macro HAZARD_STATS_EN: when defined, add output stall_count (16-bit) incrementing on every cycle with stall=1, saturating at 16'hFFFF, cleared by reset; when undefined, the port and counter SHALL NOT exist and all other behaviour is identical.

Verification
REQ-033 Load-use: ex_mem_read=1, ex_rt=8, id_rs=8, id_uses_rs=1 -> pc_write=0, if_id_write=0, id_ex_flush=1 for exactly that cycle; ex_rt=0 case -> no stall.
REQ-034 Redirect over stall: REQ-033 stimulus plus ex_redirect=1 -> pc_write=1, if_id_flush=1, id_ex_flush=1.
REQ-035 Mult/div: MD_CYCLES=4, id_md_start pulse -> md_busy=1 for 4 cycles; MFLO in ID during those cycles stalls, issues on cycle 5.
REQ-036 Back-to-back: two consecutive MULTs -> second stalled 4 cycles, md_busy high 8 consecutive cycles.
REQ-037 Reset mid-op: rst_n low at md_cnt=2 -> md_busy=0 asynchronously, no stall after release.
REQ-038 With HAZARD_STATS_EN: 3 stall cycles -> stall_count=3; preloaded to 16'hFFFF by forcing -> stays 16'hFFFF.
